// File: rtl/regread_issue_pkg.sv
// Shared constants for the register-read / issue stage.
// Op field width and the hard-wired zero register index.
package regread_issue_pkg;

  localparam int OP_WIDTH = 6;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regread_scoreboard.sv
// Per-register pending-write scoreboard for the issue stage.
// Ports: clr (write-back), kill (flushed op), set (issue), 3 lookups.
module regread_scoreboard
  import regread_issue_pkg::*;
#(
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_en,
  input  logic [ADDR_SIZE-1:0] clr_addr,
  input  logic                 kill_en,
  input  logic [ADDR_SIZE-1:0] kill_addr,
  input  logic                 set_en,
  input  logic [ADDR_SIZE-1:0] set_addr,
  input  logic [ADDR_SIZE-1:0] rs1,
  input  logic [ADDR_SIZE-1:0] rs2,
  input  logic [ADDR_SIZE-1:0] rd,
  output logic                 rs1_pend,
  output logic                 rs2_pend,
  output logic                 rd_pend
);

  localparam int NREG = 2 ** ADDR_SIZE;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  // Clears first, then set, so a same-cycle set wins.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_addr] = 1'b0;
    if (kill_en) pend_nxt[kill_addr] = 1'b0;
    if (set_en) pend_nxt[set_addr] = 1'b1;
    pend_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign rs1_pend = pend[rs1];
  assign rs2_pend = pend[rs2];
  assign rd_pend  = pend[rd];

endmodule

// File: rtl/regread_issue.sv
// Register-read / issue stage: hazard check, operand read, out reg.
// Ports: decode side in_*, regfile raddr/rdata, wb_*, flush, exec out_*.
module regread_issue
  import regread_issue_pkg::*;
#(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 32,
  parameter int OP_WIDTH  = regread_issue_pkg::OP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_SIZE-1:0] in_rs1,
  input  logic [ADDR_SIZE-1:0] in_rs2,
  input  logic [ADDR_SIZE-1:0] in_rd,
  input  logic                 in_rd_we,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic [WORD_SIZE-1:0] in_imm,
  output logic [ADDR_SIZE-1:0] raddr1,
  output logic [ADDR_SIZE-1:0] raddr2,
  input  logic [WORD_SIZE-1:0] rdata1,
  input  logic [WORD_SIZE-1:0] rdata2,
  input  logic                 wb_en,
  input  logic [ADDR_SIZE-1:0] wb_addr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_WIDTH-1:0]  out_op,
  output logic [ADDR_SIZE-1:0] out_rd,
  output logic                 out_rd_we,
  output logic [WORD_SIZE-1:0] out_a,
  output logic [WORD_SIZE-1:0] out_b,
  output logic [WORD_SIZE-1:0] out_imm
);

  localparam logic [ADDR_SIZE-1:0] X0 = ADDR_SIZE'(REG_ZERO);

  logic rs1_pend, rs2_pend, rd_pend;
  logic rs1_ok, rs2_ok, rd_ok;
  logic slot_free, issue, hs, kill, set_en;

  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  // Regfile writes at negedge, so a same-cycle write-back is readable.
  assign rs1_ok = (in_rs1 == X0) | ~rs1_pend
                | (wb_en & (wb_addr == in_rs1));
  assign rs2_ok = (in_rs2 == X0) | ~rs2_pend
                | (wb_en & (wb_addr == in_rs2));
  assign rd_ok  = ~in_rd_we | (in_rd == X0) | ~rd_pend;

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = slot_free & rs1_ok & rs2_ok & rd_ok & ~flush;
  assign issue     = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign set_en    = issue & in_rd_we & (in_rd != X0);

  // A flushed op that execute did not take will never write back.
  assign kill = flush & out_valid & out_rd_we & ~hs;

  regread_scoreboard #(
    .ADDR_SIZE(ADDR_SIZE)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .kill_en  (kill),
    .kill_addr(out_rd),
    .set_en   (set_en),
    .set_addr (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .rd       (in_rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_imm   <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_op    <= in_op;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
      out_a     <= (in_rs1 == X0) ? '0 : rdata1;
      out_b     <= (in_rs2 == X0) ? '0 : rdata2;
      out_imm   <= in_imm;
    end else if (flush | out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regread_issue.sv
// Bench for regread_issue: directed vector table plus random traffic
// against a cycle-level reference model; the bench also plays regfile.
module tb_regread_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_rd_we = 1'b0;
  logic [5:0]  in_op = '0;
  logic [31:0] in_imm = '0;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_a, out_b, out_imm;

  logic [31:0] rf [32];
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  always #5 clk = ~clk;

  regread_issue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_rd    (in_rd),
    .in_rd_we (in_rd_we),
    .in_op    (in_op),
    .in_imm   (in_imm),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op   (out_op),
    .out_rd   (out_rd),
    .out_rd_we(out_rd_we),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_imm  (out_imm)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: set of registers awaiting write-back plus
  // the instruction currently offered to execute.
  bit          m_pend [32];
  bit          m_v;
  logic [5:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [31:0] m_a, m_b, m_imm;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        ordy;
    logic        fl;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        er;
    logic        ev;
    logic        ca;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit src_ok(input logic [4:0] rs);
    return rs == 5'd0 || !m_pend[rs] || (wb_en && wb_addr == rs);
  endfunction

  function automatic bit exp_ready();
    bit dst_ok;
    dst_ok = !in_rd_we || in_rd == 5'd0 || !m_pend[in_rd];
    return (!m_v || out_ready) && src_ok(in_rs1) && src_ok(in_rs2)
           && dst_ok && !flush;
  endfunction

  // One clock: regfile write at negedge, sample, check, advance model.
  task automatic cycle(input bit tchk, input vec_t t);
    bit er, iss, hs;
    @(negedge clk);
    if (wb_en) rf[wb_addr] = wb_data;
    #1;
    er = exp_ready();
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("raddr1", 32'(raddr1), 32'(in_rs1));
    chk("raddr2", 32'(raddr2), 32'(in_rs2));
    if (m_v) begin
      chk("out_op", 32'(out_op), 32'(m_op));
      chk("out_rd", 32'(out_rd), 32'(m_rd));
      chk("out_rd_we", 32'(out_rd_we), 32'(m_we));
      chk("out_a", out_a, m_a);
      chk("out_b", out_b, m_b);
      chk("out_imm", out_imm, m_imm);
    end
    if (tchk) begin
      chk("tbl_ready", 32'(in_ready), 32'(t.er));
      chk("tbl_valid", 32'(out_valid), 32'(t.ev));
      if (t.ca) chk("tbl_a", out_a, t.ea);
    end
    iss = in_valid && er;
    hs = m_v && out_ready;
    if (wb_en) m_pend[wb_addr] = 1'b0;
    if (flush && m_v && m_we && !hs) m_pend[m_rd] = 1'b0;
    if (iss && in_rd_we && in_rd != 5'd0) m_pend[in_rd] = 1'b1;
    if (iss) begin
      m_v = 1'b1;
      m_op = in_op;
      m_rd = in_rd;
      m_we = in_rd_we;
      m_a = (in_rs1 == 5'd0) ? 32'd0 : rf[in_rs1];
      m_b = (in_rs2 == 5'd0) ? 32'd0 : rf[in_rs2];
      m_imm = in_imm;
    end else if (flush || out_ready) begin
      m_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_op", 32'(out_op), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_we", 32'(out_rd_we), 32'd0);
    chk("rst_a", out_a, 32'd0);
    chk("rst_b", out_b, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    in_valid = 1'b0;
    flush = 1'b0;
    wb_en = 1'b0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_rd = '0;
    in_rd_we = 1'b1;
    m_v = 1'b0;
    m_op = '0;
    m_rd = '0;
    m_we = 1'b0;
    m_a = '0;
    m_b = '0;
    m_imm = '0;
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready_x0", 32'(in_ready), 32'd1);
  endtask

  task automatic apply(input vec_t t, input int i);
    in_valid = t.v;
    in_rs1 = t.rs1;
    in_rs2 = t.rs2;
    in_rd = t.rd;
    in_rd_we = t.we;
    in_op = 6'(i);
    in_imm = 32'h100 + 32'(i);
    out_ready = t.ordy;
    flush = t.fl;
    wb_en = t.wbe;
    wb_addr = t.wba;
    wb_data = t.wbd;
  endtask

  initial begin
    vec_t none;
    none = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
             32'd0, 1'b0, 1'b0, 1'b0, 32'd0};
    for (int r = 0; r < 32; r++) rf[r] = 32'hA000_0000 | 32'(r);
    rf[0] = 32'h1234_5678;

    // v rs1 rs2 rd we ordy fl wbe wba wbd | er ev ca ea
    tbl[0]  = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 5'd5, 5'd6, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b1, 1'b1, 1'b1, 32'hA000_0001};
    tbl[2]  = '{1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b0, 1'b1, 1'b1, 32'hA000_0005};
    tbl[3]  = '{1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,
                32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[4]  = '{1'b1, 5'd0, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b0, 1'b1, 1'b1, 32'd0};
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = '{1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b1, 1'b1, 1'b1, 32'd0};
    tbl[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7,
                32'h77, 1'b1, 1'b1, 1'b1, 32'hA000_0001};
    tbl[10] = '{1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,
                32'd0, 1'b0, 1'b1, 1'b1, 32'hA000_0001};
    tbl[12] = '{1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[13] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,
                32'd0, 1'b1, 1'b1, 1'b1, 32'h77};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i], i);
      cycle(1'b1, tbl[i]);
    end

    // Reset while an instruction is held under backpressure.
    in_valid = 1'b1;
    in_rs1 = 5'd1;
    in_rs2 = 5'd2;
    in_rd = 5'd5;
    in_rd_we = 1'b1;
    out_ready = 1'b0;
    flush = 1'b0;
    wb_en = 1'b0;
    cycle(1'b0, none);
    in_valid = 1'b0;
    cycle(1'b0, none);
    chk("held_before_reset", 32'(out_valid), 32'd1);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2000) do_reset();
      in_valid = ($urandom % 4) != 0;
      in_rs1 = 5'($urandom_range(0, 7));
      in_rs2 = 5'($urandom_range(0, 7));
      in_rd = 5'($urandom_range(0, 7));
      in_rd_we = ($urandom % 4) != 0;
      in_op = 6'($urandom);
      in_imm = $urandom;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 16) == 0;
      wb_en = ($urandom % 3) == 0;
      wb_addr = 5'($urandom_range(1, 7));
      wb_data = $urandom;
      cycle(1'b0, none);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule
